// File: rtl/progloader.sv
// progloader: boot-time program loader.
//
// Receives a byte stream over a valid/ready handshake. The stream holds a
// 2-byte little-endian word count N, then N little-endian 32-bit words, then
// a 1-byte checksum (the XOR of all data bytes). Each word is written to
// instruction memory at byte address (word index * 4). The CPU datapath is
// held in reset (cpu_rst low) until the image has loaded and its checksum
// has matched.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   start     single-cycle pulse; restarts loading from DONE or ERR
//   in_valid  in_data holds a valid byte
//   in_data   stream byte
//   in_ready  loader accepts a byte this cycle
//   memwe     instruction memory write strobe (WRITE state only)
//   memaddr   byte address of the word being written
//   memwdata  instruction word being written
//   cpu_rst   active-low datapath reset; high only in DONE
//   done      image loaded and verified
//   error     image rejected (oversize count or checksum mismatch)
module progloader #(
    parameter int DEPTH    = 256,
    parameter int ADDRSIZE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                memwe,
    output logic [ADDRSIZE-1:0] memaddr,
    output logic [31:0]         memwdata,
    output logic                cpu_rst,
    output logic                done,
    output logic                error
);

    typedef enum logic [2:0] {
        S_LEN0  = 3'd0,
        S_LEN1  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_SUM   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    // One extra bit so a 16-bit count can be compared against DEPTH = 65536.
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t                state_reg;
    state_t                state_next;

    logic [7:0]            count_lo_reg;
    logic [15:0]           count_reg;
    logic [15:0]           word_idx_reg;
    logic [1:0]            byte_cnt_reg;
    logic [31:0]           shift_reg;
    logic [7:0]            xor_reg;
    logic [ADDRSIZE-1:0]   memaddr_reg;
    logic [31:0]           memwdata_reg;

    logic                  accept;
    logic [15:0]           count_in;
    logic [31:0]           word_next;

    assign accept   = in_ready & in_valid;
    assign count_in = {in_data, count_lo_reg};

    // Shift assembler: new bytes enter at the top and move down, so after
    // four bytes the first one received sits in bits [7:0].
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        if (gi == 3) begin : g_top
            assign word_next[gi*8 +: 8] = in_data;
        end else begin : g_low
            assign word_next[gi*8 +: 8] = shift_reg[(gi+1)*8 +: 8];
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_LEN0;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_LEN0: begin
                if (accept) state_next = S_LEN1;
            end
            S_LEN1: begin
                if (accept) begin
                    if ({1'b0, count_in} > DEPTH_W) state_next = S_ERR;
                    else if (count_in == 16'd0)     state_next = S_SUM;
                    else                            state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && byte_cnt_reg == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                // word_idx_reg still holds the index of the word being written.
                if (word_idx_reg + 16'd1 == count_reg) state_next = S_SUM;
                else                                   state_next = S_DATA;
            end
            S_SUM: begin
                if (accept) state_next = (in_data == xor_reg) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (start) state_next = S_LEN0;
            end
            default: state_next = S_LEN0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_lo_reg <= '0;
            count_reg    <= '0;
            word_idx_reg <= '0;
            byte_cnt_reg <= '0;
            shift_reg    <= '0;
            xor_reg      <= '0;
            memaddr_reg  <= '0;
            memwdata_reg <= '0;
        end else begin
            case (state_reg)
                S_LEN0: begin
                    if (accept) count_lo_reg <= in_data;
                end
                S_LEN1: begin
                    if (accept) count_reg <= count_in;
                end
                S_DATA: begin
                    if (accept) begin
                        shift_reg    <= word_next;
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        xor_reg      <= xor_reg ^ in_data;
                        // Load the write port on the 4th byte so address and
                        // data are already stable throughout the WRITE cycle,
                        // and hold there afterwards.
                        if (byte_cnt_reg == 2'd3) begin
                            memaddr_reg  <= ADDRSIZE'({word_idx_reg, 2'b00});
                            memwdata_reg <= word_next;
                        end
                    end
                end
                S_WRITE: begin
                    word_idx_reg <= word_idx_reg + 16'd1;
                end
                S_DONE, S_ERR: begin
                    if (start) begin
                        word_idx_reg <= '0;
                        byte_cnt_reg <= '0;
                        xor_reg      <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state or driven from registers only
    // ------------------------------------------------------------------
    always_comb begin
        // in_ready is gated by rst so it is low during reset even though the
        // reset state is LEN0.
        in_ready = 1'b0;
        memwe    = 1'b0;
        cpu_rst  = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        memaddr  = memaddr_reg;
        memwdata = memwdata_reg;
        case (state_reg)
            S_LEN0, S_LEN1, S_DATA, S_SUM: in_ready = rst;
            S_WRITE:                       memwe    = 1'b1;
            S_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b1;
            end
            S_ERR:                         error    = 1'b1;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_progloader.sv
// Directed testbench for progloader. Writes are captured by a monitor on the
// falling edge; all expected values are hand-computed constants.
module tb_progloader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        memwe;
    logic [15:0] memaddr;
    logic [31:0] memwdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int vectors     = 0;
    int miscompares = 0;
    int low_cycles  = 0;

    logic [15:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic        wq_rdy[$];

    progloader #(.DEPTH(256), .ADDRSIZE(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .memwe    (memwe),
        .memaddr  (memaddr),
        .memwdata (memwdata),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor and in_ready-low cycle counter (mid-cycle sampling).
    always @(negedge clk) begin
        if (memwe) begin
            wq_addr.push_back(memaddr);
            wq_data.push_back(memwdata);
            wq_rdy.push_back(in_ready);
        end
        if (rst && !in_ready && !done && !error) low_cycles++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s observed %h expected %h", vectors, tag, obs, exp);
    endtask

    // Called at a falling edge; returns at the falling edge after transfer.
    task automatic send(input logic [7:0] b, input bit stall);
        int guard;
        int n;
        guard = 0;
        n = 0;
        if (stall) begin
            while ($urandom_range(0, 1) == 1 && n < 8) begin
                in_valid = 1'b0;
                @(negedge clk);
                n++;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            check("send_timeout", 32'(guard), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall);
        for (int i = 0; i < 4; i++) send(w[i*8 +: 8], stall);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_writes();
        wq_addr.delete();
        wq_data.delete();
        wq_rdy.delete();
    endtask

    task automatic load_three(input bit stall, input string tag);
        clear_writes();
        low_cycles = 0;
        send(8'h03, stall);
        send(8'h00, stall);
        send_word(32'h1111_1111, stall);
        send_word(32'h2222_2222, stall);
        send_word(32'h3333_3333, stall);
        send(8'h00, stall);
        check({tag, "_nwrites"}, 32'(wq_addr.size()), 32'd3);
        if (wq_addr.size() == 3) begin
            check({tag, "_addr0"}, 32'(wq_addr[0]), 32'h0);
            check({tag, "_addr1"}, 32'(wq_addr[1]), 32'h4);
            check({tag, "_addr2"}, 32'(wq_addr[2]), 32'h8);
            check({tag, "_data0"}, wq_data[0], 32'h1111_1111);
            check({tag, "_data1"}, wq_data[1], 32'h2222_2222);
            check({tag, "_data2"}, wq_data[2], 32'h3333_3333);
            check({tag, "_rdy_w"}, {29'd0, wq_rdy[0], wq_rdy[1], wq_rdy[2]}, 32'd0);
        end
        check({tag, "_low_cycles"}, 32'(low_cycles), 32'd3);
        check({tag, "_done"}, {30'd0, done, cpu_rst}, 32'b11);
        check({tag, "_hold_addr"}, 32'(memaddr), 32'h8);
        check({tag, "_hold_data"}, memwdata, 32'h3333_3333);
    endtask

    task automatic load_one(input logic [7:0] sum, input string tag);
        clear_writes();
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send_word(32'h8B00_0013, 1'b0);
        send(sum, 1'b0);
        check({tag, "_nwrites"}, 32'(wq_addr.size()), 32'd1);
        if (wq_addr.size() == 1) begin
            check({tag, "_addr"}, 32'(wq_addr[0]), 32'h0);
            check({tag, "_data"}, wq_data[0], 32'h8B00_0013);
        end
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_memwe", 32'(memwe), 32'd0);
        check("rst_memaddr", 32'(memaddr), 32'd0);
        check("rst_memwdata", memwdata, 32'd0);
        check("rst_flags", {29'd0, cpu_rst, done, error}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // 1-word image, correct checksum.
        load_one(8'h98, "one");
        check("one_done_cpu", {30'd0, done, cpu_rst}, 32'b11);
        check("one_error", 32'(error), 32'd0);
        check("one_ready_after", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("one_done_hold", 32'(done), 32'd1);

        // 3-word image, no stalls, then with random stalls.
        pulse_start();
        check("restart_flags", {29'd0, cpu_rst, done, error}, 32'd0);
        check("restart_ready", 32'(in_ready), 32'd1);
        load_three(1'b0, "three");
        pulse_start();
        load_three(1'b1, "stall");

        // Oversize count 0x0101.
        pulse_start();
        clear_writes();
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        check("big_error", {29'd0, error, done, cpu_rst}, 32'b100);
        check("big_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("big_nwrites", 32'(wq_addr.size()), 32'd0);
        check("big_error_hold", {30'd0, error, cpu_rst}, 32'b10);
        pulse_start();
        check("big_restart", {29'd0, error, done, in_ready}, 32'b001);
        load_one(8'h98, "big_reload");
        check("big_reload_done", {29'd0, done, cpu_rst, error}, 32'b110);

        // Bad checksum.
        pulse_start();
        load_one(8'h99, "badsum");
        check("badsum_flags", {29'd0, error, done, cpu_rst}, 32'b100);

        // Reset mid-image after two data bytes.
        pulse_start();
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'h13, 1'b0);
        send(8'h00, 1'b0);
        clear_writes();
        rst = 1'b0;
        #1;
        check("midrst_ready", 32'(in_ready), 32'd0);
        check("midrst_memaddr", 32'(memaddr), 32'd0);
        check("midrst_memwdata", memwdata, 32'd0);
        check("midrst_flags", {28'd0, memwe, cpu_rst, done, error}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_nwrites", 32'(wq_addr.size()), 32'd0);
        load_one(8'h98, "midrst_reload");
        check("midrst_reload_done", {29'd0, done, cpu_rst, error}, 32'b110);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/progloader.md
# progloader

Boot-time program loader. It receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into instruction memory starting at byte address 0. It holds the CPU datapath in reset until the image has loaded and its checksum has verified. It is the write side of the instruction memory that the datapath fetches from via `pc`.

## Interface
- `DEPTH`, default 256: instruction memory capacity in words.
- `ADDRSIZE`, default 16: width of the byte address presented to instruction memory.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse; restarts loading from the DONE or ERR state.
- `in_valid`  in  1  `in_data` holds a valid byte.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `memwe`  out  1  instruction memory write strobe.
- `memaddr`  out  `ADDRSIZE`  byte address of the word being written (word index × 4).
- `memwdata`  out  32  instruction word to write.
- `cpu_rst`  out  1  active-low reset to the datapath; low except in DONE.
- `done`  out  1  image loaded and verified.
- `error`  out  1  image rejected.

## Operation
- Stream format, in order:
  - count: 2 bytes, little-endian word count N.
  - data: N×4 bytes, each word little-endian (first byte goes to bits [7:0]).
  - checksum: 1 byte, the XOR of all data bytes. Count bytes are not included.
- A byte transfers on a rising edge where `in_valid` and `in_ready` are both 1.
- States:
  - LEN0: accept count low byte, then go to LEN1.
  - LEN1: accept count high byte. If N > `DEPTH`, go to ERR. If N == 0, go to SUM. Otherwise go to DATA.
  - DATA: accept bytes into a 32-bit shift assembler and keep a 2-bit byte counter. On the 4th byte, go to WRITE.
  - WRITE: one cycle. Then go to DATA if fewer than N words are written, otherwise go to SUM.
  - SUM: accept one byte. Go to DONE if it equals the running XOR, otherwise go to ERR.
  - DONE: `start` goes to LEN0.
  - ERR: `start` goes to LEN0.
- `start` is ignored in all other states.
- `in_ready` = 1 in LEN0, LEN1, DATA and SUM; 0 in WRITE, DONE and ERR; forced 0 while `rst` is low.
- `memwe` = 1 only in WRITE. During that cycle `memaddr` = word index × 4 and `memwdata` = the assembled word; both hold their last value otherwise.
- Word index is 0..N-1 with no wrap, since N ≤ `DEPTH` is guaranteed by the LEN1 check.
- Restarting via `start` clears the word index, byte counter and XOR accumulator, and drives `cpu_rst` low again.
- `done` = 1 only in DONE; `error` = 1 only in ERR. The two are mutually exclusive.
- Data already written before an ERR is not rolled back. `cpu_rst` stays low in ERR.
- `in_valid` low stalls the FSM in its current state with no timeout.

## Timing
- Reset values (while `rst` is low): state LEN0, `in_ready` 0, `memwe` 0, `memaddr` 0, `memwdata` 0, `cpu_rst` 0, `done` 0, `error` 0, counters and accumulator 0.
- Reset mid-load abandons the image immediately, with no write in flight afterwards.
- Each word costs at least 5 cycles: 4 accept cycles plus 1 WRITE cycle with `in_ready` = 0.
- The memory samples `memwe`, `memaddr` and `memwdata` on the same rising edge that leaves WRITE.
- `done` and `cpu_rst` rise on the edge that accepts a matching checksum byte. The datapath leaves reset from the next edge on.
- `error` rises on the edge that accepts the LEN1 byte (oversize count) or the SUM byte (checksum mismatch).
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid` or `in_data` to any output.

## Test plan
- Reset, then stream 01 00 13 00 00 8B 98 with no stalls:
  - one write: `memaddr` 0x0000, `memwdata` 0x8B000013;
  - `done` = 1 and `cpu_rst` = 1 on the edge accepting 0x98;
  - `in_ready` = 0 afterwards.
- Stream count 3 (03 00) with words 0x11111111, 0x22222222, 0x33333333 and checksum 0x00:
  - writes at addresses 0, 4, 8 in that order;
  - `in_ready` = 0 exactly on each WRITE cycle.
- Repeat the 3-word load with `in_valid` randomly deasserted 50% of cycles:
  - identical writes and final state;
  - no byte is lost or duplicated.
- Stream count 0x0101 (257 > `DEPTH`):
  - `error` = 1 after the second count byte;
  - no `memwe` pulse;
  - `cpu_rst` stays 0;
  - a `start` pulse returns to LEN0 and a correct image then loads.
- Stream the 1-word image with checksum 0x99:
  - the word is written;
  - `error` = 1, `done` = 0, `cpu_rst` = 0.
- Pull `rst` low after 2 data bytes of a 1-word image, then release and send the full 1-word image:
  - no write occurs before the reset;
  - the full image loads correctly with `memaddr` 0.
